// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Purpose : Shared definitions for the delay-buffer fifo and the blocks that
//           wrap or drain it. The fifo, its unloader and any wrappers import
//           this package, so they agree on default geometry and state
//           encoding.
//
// Contents:
//   DEFAULT_DEPTH / DEFAULT_BITS - default fifo geometry (entries / word bits)
//   fifo_state_t                 - unloader FSM states (IDLE, PRESENT, DONE)
//   count_width(depth)           - bits needed to hold 0..depth
//   idx_width(depth)             - bits needed to hold 0..depth-1 (min 1)
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_BITS  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DONE    = 2'd2
  } fifo_state_t;

  // Width of a counter that must reach depth itself (words captured so far).
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into depth entries. A single-entry fifo would give
  // $clog2(1) = 0, which is not a legal vector width, so clamp to 1.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_unloader.sv
// ---------------------------------------------------------------------------
// fifo_unloader
//
// Purpose : Read-side controller for one delay-buffer fifo instance. On a
//           start command it drains all DEPTH entries, oldest first: each
//           word is captured from fifo_q while fifo_en shifts the fifo, then
//           presented on a valid/ready stream toward the MMIO read-back path.
//           A done pulse follows acceptance of the last word.
//
// Build option:
//   FIFO_UNLOADER_RECIRC_EN - when defined, every shifted-out word is written
//                             back into the fifo tail (fifo_d = fifo_q), so a
//                             full drain leaves the fifo contents unchanged.
//                             When undefined, zeros are shifted in and a full
//                             drain leaves the fifo in its reset state.
//
// Parameters:
//   DEPTH - fifo entries drained per command (must match the attached fifo)
//   BITS  - word width of fifo data and the output stream
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset (shared with the fifo)
//   start     in   begin a drain; only sampled in IDLE
//   abort     in   cancel the drain; back to IDLE next cycle, no done pulse
//   fifo_q    in   oldest entry of the attached fifo
//   fifo_en   out  fifo shift enable (combinational, same cycle as capture)
//   fifo_d    out  word shifted into the fifo tail on each fifo_en
//   out_valid out  out_data holds a word not yet accepted
//   out_ready in   consumer accepts out_data when high with out_valid
//   out_data  out  captured word (registered)
//   out_idx   out  index of the presented word, 0 = oldest
//   busy      out  high in any state other than IDLE
//   done      out  one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module fifo_unloader
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int BITS  = DEFAULT_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [BITS-1:0]              fifo_q,
  output logic                         fifo_en,
  output logic [BITS-1:0]              fifo_d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BITS-1:0]              out_data,
  output logic [idx_width(DEPTH)-1:0]  out_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int IDX_W = idx_width(DEPTH);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEPTH);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  fifo_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;   // words captured this drain
  logic [IDX_W-1:0]  idx_reg,   idx_next;
  logic [BITS-1:0]   data_reg,  data_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and fifo shift control
  //
  // A capture and its fifo_en pulse always happen together: the word on
  // fifo_q is latched on the same edge that advances the fifo, so fifo_q
  // already shows the next-oldest entry one cycle later. That is what lets a
  // consumer holding out_ready high take one word per cycle.
  //
  // abort wins over start and out_ready in every state; it never shifts the
  // fifo and never produces a done pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    fifo_en    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!abort && start) begin
          fifo_en    = 1'b1;
          data_next  = fifo_q;
          count_next = CNT_W'(1);
          idx_next   = '0;
          state_next = PRESENT;
        end
      end

      PRESENT: begin
        if (abort) begin
          state_next = IDLE;
        end else if (out_ready) begin
          if (count_reg != LAST_COUNT) begin
            // Current word accepted and more remain: fetch the next one now.
            fifo_en    = 1'b1;
            data_next  = fifo_q;
            count_next = count_reg + CNT_W'(1);
            idx_next   = idx_reg + IDX_W'(1);
          end else begin
            // Last word accepted; the fifo has already been shifted DEPTH
            // times, so no further pulse.
            state_next = DONE;
          end
        end
        // out_ready low: hold data and index, fifo untouched.
      end

      DONE: begin
        // start here is deliberately ignored; it must be seen again in IDLE.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  //
  // Status outputs are plain decodes of the state register, so out_valid
  // can only fall by leaving PRESENT: via the final handshake, abort or reset.
  // -------------------------------------------------------------------------
  assign out_valid = (state_reg == PRESENT);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign out_data  = data_reg;
  assign out_idx   = idx_reg;

`ifdef FIFO_UNLOADER_RECIRC_EN
  // Write each departing word back into the tail: after DEPTH shifts the
  // fifo holds its original contents in the original order.
  assign fifo_d = fifo_q;
`else
  // Shift in zeros: a full drain leaves the fifo matching its reset contents.
  assign fifo_d = '0;
`endif

endmodule

// File: tb/tb_fifo_unloader.sv
// ---------------------------------------------------------------------------
// tb_fifo_unloader
//
// Bench for fifo_unloader (DEPTH=8, BITS=64) with a small shift-register
// fifo model as the partner block. The model shifts on either the
// unloader's fifo_en or a bench-side fill strobe and is cleared by rst_n.
// Honours FIFO_UNLOADER_RECIRC_EN for the expected second-drain contents.
// ---------------------------------------------------------------------------
module tb_fifo_unloader;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;

`ifdef FIFO_UNLOADER_RECIRC_EN
  localparam bit RECIRC = 1'b1;
`else
  localparam bit RECIRC = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic [BITS-1:0] fifo_q;
  logic            fifo_en;
  logic [BITS-1:0] fifo_d;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic [2:0]      out_idx;
  logic            busy;
  logic            done;

  fifo_unloader #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .fifo_q    (fifo_q),
    .fifo_en   (fifo_en),
    .fifo_d    (fifo_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- partner fifo model ----------------
  logic [BITS-1:0] fmem [0:DEPTH-1];
  logic            fill_wr;
  logic [BITS-1:0] fill_d;

  assign fifo_q = fmem[0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fmem[i] <= '0;
    end else if (fifo_en || fill_wr) begin
      for (int i = 0; i < DEPTH - 1; i++) fmem[i] <= fmem[i+1];
      fmem[DEPTH-1] <= fill_wr ? fill_d : fifo_d;
    end
  end

  // fifo_en pulses seen on active edges
  int en_cnt;
  always @(posedge clk) begin
    if (rst_n && fifo_en) en_cnt = en_cnt + 1;
  end

  // ---------------- bookkeeping ----------------
  int n_checks;
  int n_fail;

  logic [BITS-1:0] got_data [0:15];
  int              got_idx  [0:15];
  int              got_cyc  [0:15];
  int              n_got;
  int              done_cnt;
  int              done_cyc;
  int              stall_change;
  bit              timed_out;
  logic            done_valid;
  logic            post_valid;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic fill(input logic [BITS-1:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      fill_wr = 1'b1;
      fill_d  = base + BITS'(i);
      tick();
    end
    fill_wr = 1'b0;
  endtask

  // Runs one drain from IDLE and records what the stream delivered.
  // toggle: out_ready alternates 1,0,1,0... instead of held high.
  // abort_after > 0: assert abort once that many words were accepted.
  task automatic drain(input bit toggle, input int abort_after);
    logic [BITS-1:0] held;
    bit              held_v;
    bit              phase;
    logic            rdy;
    n_got = 0; done_cnt = 0; done_cyc = -1; stall_change = 0;
    timed_out = 1'b0; held_v = 1'b0; phase = 1'b1; en_cnt = 0;
    done_valid = 1'bx; post_valid = 1'bx;
    held = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (!busy) begin
        post_valid = out_valid;
        break;
      end
      if (cyc == 63) timed_out = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        done_valid = out_valid;
      end
      rdy = 1'b0;
      if (out_valid) begin
        if (held_v && out_data !== held) stall_change++;
        if (abort_after > 0 && n_got == abort_after) begin
          abort = 1'b1;
        end else begin
          rdy = toggle ? phase : 1'b1;
          phase = ~phase;
        end
        if (rdy) begin
          if (n_got < 16) begin
            got_data[n_got] = out_data;
            got_idx[n_got]  = int'(out_idx);
            got_cyc[n_got]  = cyc;
          end
          $display("word %0d idx %0d data %h cyc %0d", n_got, out_idx, out_data, cyc);
          n_got++;
          held_v = 1'b0;
        end else begin
          held   = out_data;
          held_v = 1'b1;
        end
      end
      out_ready = rdy;
      tick();
      abort = 1'b0;
    end
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    n_checks++; if (fifo_en !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_en: got %b want 0", fifo_en); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_drain;
    do_reset();
    fill(64'd1);
    // fifo_en must be asserted combinationally in the start cycle
    start = 1'b1;
    #1;
    n_checks++; if (fifo_en !== 1'b1) begin n_fail++; $display("FAIL full_start_en: got %b want 1", fifo_en); end
    drain(1'b0, 0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL full_timeout: drain did not finish"); end
    n_checks++; if (n_got !== DEPTH) begin n_fail++; $display("FAIL full_count: got %0d words want %0d", n_got, DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (got_data[k] !== 64'(k + 1)) begin n_fail++; $display("FAIL full_data[%0d]: got %h want %h", k, got_data[k], 64'(k + 1)); end
      n_checks++; if (got_idx[k] !== k) begin n_fail++; $display("FAIL full_idx[%0d]: got %0d want %0d", k, got_idx[k], k); end
      n_checks++; if (got_cyc[k] !== k) begin n_fail++; $display("FAIL full_cycle[%0d]: got %0d want %0d", k, got_cyc[k], k); end
    end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc !== DEPTH) begin n_fail++; $display("FAIL full_done_cyc: got %0d want %0d", done_cyc, DEPTH); end
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL full_done_valid: got %b want 0", done_valid); end
    n_checks++; if (en_cnt !== DEPTH) begin n_fail++; $display("FAIL full_en_cnt: got %0d want %0d", en_cnt, DEPTH); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_backpressure;
    do_reset();
    fill(64'd1);
    drain(1'b1, 0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: drain did not finish"); end
    n_checks++; if (n_got !== DEPTH) begin n_fail++; $display("FAIL bp_count: got %0d words want %0d", n_got, DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (got_data[k] !== 64'(k + 1)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", k, got_data[k], 64'(k + 1)); end
      n_checks++; if (got_idx[k] !== k) begin n_fail++; $display("FAIL bp_idx[%0d]: got %0d want %0d", k, got_idx[k], k); end
    end
    n_checks++; if (stall_change !== 0) begin n_fail++; $display("FAIL bp_stable: %0d words changed while stalled, want 0", stall_change); end
    n_checks++; if (en_cnt !== DEPTH) begin n_fail++; $display("FAIL bp_en_cnt: got %0d want %0d", en_cnt, DEPTH); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort;
    do_reset();
    fill(64'd1);
    drain(1'b0, 3);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL abort_timeout: FSM did not return to IDLE"); end
    n_checks++; if (n_got !== 3) begin n_fail++; $display("FAIL abort_count: got %0d words want 3", n_got); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (got_data[k] !== 64'(k + 1)) begin n_fail++; $display("FAIL abort_data[%0d]: got %h want %h", k, got_data[k], 64'(k + 1)); end
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
    n_checks++; if (post_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid_next: got %b want 0", post_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_checks++; if (en_cnt !== 4) begin n_fail++; $display("FAIL abort_en_cnt: got %0d want 4", en_cnt); end
    n_checks++; if (fifo_q !== 64'd5) begin n_fail++; $display("FAIL abort_fifo_head: got %h want 5", fifo_q); end
  endtask

  task automatic test_recirc;
    logic [BITS-1:0] exp;
    do_reset();
    fill(64'hA0);
    drain(1'b0, 0);
    n_checks++; if (n_got !== DEPTH) begin n_fail++; $display("FAIL recirc_count1: got %0d words want %0d", n_got, DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (got_data[k] !== 64'(8'hA0 + k)) begin n_fail++; $display("FAIL recirc_first[%0d]: got %h want %h", k, got_data[k], 64'(8'hA0 + k)); end
    end
    drain(1'b0, 0);
    n_checks++; if (n_got !== DEPTH) begin n_fail++; $display("FAIL recirc_count2: got %0d words want %0d", n_got, DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      exp = RECIRC ? 64'(8'hA0 + k) : 64'd0;
      n_checks++; if (got_data[k] !== exp) begin n_fail++; $display("FAIL recirc_second[%0d]: got %h want %h", k, got_data[k], exp); end
    end
  endtask

  task automatic test_reset_mid_drain;
    do_reset();
    fill(64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    n_checks++; if (out_idx !== 3'd4) begin n_fail++; $display("FAIL midrst_pre_idx: got %0d want 4", out_idx); end
    n_checks++; if (out_data !== 64'd5) begin n_fail++; $display("FAIL midrst_pre_data: got %h want 5", out_data); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", out_data); end
    n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL midrst_idx: got %0d want 0", out_idx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    tick();
    drain(1'b0, 0);
    n_checks++; if (n_got !== DEPTH) begin n_fail++; $display("FAIL midrst_count: got %0d words want %0d", n_got, DEPTH); end
    for (int k = 0; k < DEPTH; k++) begin
      n_checks++; if (got_data[k] !== 64'd0) begin n_fail++; $display("FAIL midrst_data[%0d]: got %h want 0", k, got_data[k]); end
    end
  endtask

  task automatic test_start_held;
    int hs;
    bit seen_done;
    do_reset();
    fill(64'd1);
    hs = 0;
    seen_done = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int cyc = 0; cyc < 40 && !seen_done; cyc++) begin
      if (done) begin
        seen_done = 1'b1;
        n_checks++; if (fifo_en !== 1'b0) begin n_fail++; $display("FAIL held_done_en: got %b want 0", fifo_en); end
      end else begin
        if (out_valid) hs++;
        tick();
      end
    end
    n_checks++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL held_timeout: no done pulse"); end
    n_checks++; if (hs !== DEPTH) begin n_fail++; $display("FAIL held_words: got %0d handshakes want %0d", hs, DEPTH); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_idle_busy: got %b want 0", busy); end
    n_checks++; if (fifo_en !== 1'b1) begin n_fail++; $display("FAIL held_idle_en: got %b want 1", fifo_en); end
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_restart_busy: got %b want 1", busy); end
    n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL held_restart_idx: got %0d want 0", out_idx); end
    n_checks++; if (out_data !== (RECIRC ? 64'd1 : 64'd0)) begin n_fail++; $display("FAIL held_restart_data: got %h want %h", out_data, (RECIRC ? 64'd1 : 64'd0)); end
    start = 1'b0;
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_abort_busy: got %b want 0", busy); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; en_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    fill_wr = 1'b0; fill_d = '0;
    test_reset();
    test_full_drain();
    test_backpressure();
    test_abort();
    test_recirc();
    test_reset_mid_drain();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
